// File: rtl/sd_sector_buffer.sv
// Captures one 512-byte SD data block plus its CRC16 into a 512x8 RAM, checks
// CRC16-CCITT on the fly, and holds the sector for random-access reads until released.
module sd_sector_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rvalid,
  input  logic [15:0] rindex,
  input  logic [7:0]  rdata,
  input  logic        abort,
  input  logic        clear,
  input  logic        release_sector,
  input  logic [8:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        sector_ready,
  output logic        crc_ok,
  output logic [15:0] crc_calc,
  output logic [15:0] crc_rx,
  output logic        busy,
  output logic        seq_err,
  output logic        overrun
);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  exp_reg, exp_next;
  logic [15:0] crc_reg, crc_next;
  logic [15:0] crc_rx_reg, crc_rx_next;
  logic        crc_ok_reg, crc_ok_next;
  logic        seq_err_reg, seq_err_next;
  logic        overrun_reg, overrun_next;
  logic        we;
  logic [8:0]  waddr;
  logic        first_byte;
  logic        idx_match;

  logic [7:0]  mem [512];

  // MSB-first CRC16-CCITT (poly 0x1021), all eight bits folded in one cycle.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign first_byte = rvalid && (rindex == 16'd513);
  assign idx_match  = rindex == {6'd0, exp_reg};
  // 513 - rindex modulo 512; rindex is 2..513 whenever this address is used.
  assign waddr      = first_byte ? 9'd0 : 9'd1 - rindex[8:0];

  always_comb begin
    state_next   = state_reg;
    exp_next     = exp_reg;
    crc_next     = crc_reg;
    crc_rx_next  = crc_rx_reg;
    crc_ok_next  = crc_ok_reg;
    seq_err_next = seq_err_reg;
    overrun_next = overrun_reg;
    we           = 1'b0;

    if (clear || abort) begin
      state_next = S_EMPTY;
      exp_next   = 10'd513;
      if (clear) begin
        seq_err_next = 1'b0;
        overrun_next = 1'b0;
      end
    end else begin
      case (state_reg)
        S_EMPTY: begin
          if (first_byte) begin
            we         = 1'b1;
            crc_next   = crc_byte(16'h0000, rdata);
            exp_next   = 10'd512;
            state_next = S_FILL;
          end
        end
        S_FILL: begin
          if (rvalid && idx_match) begin
            exp_next = exp_reg - 10'd1;
            if (exp_reg >= 10'd2) begin
              we       = 1'b1;
              crc_next = crc_byte(crc_reg, rdata);
            end else if (exp_reg == 10'd1) begin
              crc_rx_next[15:8] = rdata;
            end else begin
              crc_rx_next[7:0] = rdata;
              crc_ok_next      = crc_reg == {crc_rx_reg[15:8], rdata};
              state_next       = S_FULL;
            end
          end else if (rvalid) begin
            seq_err_next = 1'b1;
            if (first_byte) begin
              we       = 1'b1;
              crc_next = crc_byte(16'h0000, rdata);
              exp_next = 10'd512;
            end else begin
              state_next = S_EMPTY;
              exp_next   = 10'd513;
            end
          end
        end
        S_FULL: begin
          if (release_sector) begin
            if (first_byte) begin
              we         = 1'b1;
              crc_next   = crc_byte(16'h0000, rdata);
              exp_next   = 10'd512;
              state_next = S_FILL;
            end else begin
              state_next = S_EMPTY;
              exp_next   = 10'd513;
            end
          end else if (rvalid) begin
            overrun_next = 1'b1;
          end
        end
        default: begin
          state_next = S_EMPTY;
          exp_next   = 10'd513;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_EMPTY;
      exp_reg     <= 10'd513;
      crc_reg     <= 16'h0000;
      crc_rx_reg  <= 16'h0000;
      crc_ok_reg  <= 1'b0;
      seq_err_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      exp_reg     <= exp_next;
      crc_reg     <= crc_next;
      crc_rx_reg  <= crc_rx_next;
      crc_ok_reg  <= crc_ok_next;
      seq_err_reg <= seq_err_next;
      overrun_reg <= overrun_next;
    end
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end

  assign sector_ready = state_reg == S_FULL;
  assign busy         = state_reg == S_FILL;
  assign crc_ok       = crc_ok_reg;
  assign crc_calc     = crc_reg;
  assign crc_rx       = crc_rx_reg;
  assign seq_err      = seq_err_reg;
  assign overrun      = overrun_reg;

endmodule
